io_capture_packer: RTL and testbench

Downstream stage for the IOB-forced capture registers. It accepts one `width`-bit sample per valid cycle from a captured IO bus and packs `ratio` consecutive samples into one wide word. Words are buffered in a small FIFO and presented on a valid/ready output toward the fabric-side consumer. Overflow is reported explicitly, and words are never silently corrupted.

---
 rtl/io_capture_packer_pkg.sv | 14 +
 rtl/io_word_fifo.sv | 68 ++++++
 rtl/io_capture_packer.sv | 106 ++++++++++
 tb/tb_io_capture_packer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/io_capture_packer_pkg.sv
// rtl/io_capture_packer_pkg.sv - shared constants and helpers for io_capture_packer
package io_capture_packer_pkg;

  localparam int DROP_COUNT_WIDTH = 16;
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT_MAX = 16'hFFFF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/io_word_fifo.sv
// rtl/io_word_fifo.sv - first-word-fall-through word FIFO with level output
// A push into a full FIFO is accepted when a pop happens on the same edge.
module io_word_fifo
  import io_capture_packer_pkg::*;
#(
  parameter int dw    = 32,
  parameter int depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [dw-1:0]         push_data,
  output logic                  push_accept,
  input  logic                  pop_ready,
  output logic [dw-1:0]         head_data,
  output logic                  head_valid,
  output logic [clog2(depth):0] level
);

  localparam int AW = clog2(depth);
  localparam int LW = AW + 1;

  logic [dw-1:0] mem_q [depth];
  logic [dw-1:0] mem_d [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          pop;
  logic          full;
  logic          push_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = (level_q != '0) && pop_ready;
    full     = (level_q == LW'(depth));
    push_ok  = push && (!full || pop);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign push_accept = push_ok;
  assign head_data   = mem_q[rd_ptr_q];
  assign head_valid  = (level_q != '0);
  assign level       = level_q;

endmodule

// File: rtl/io_capture_packer.sv
// rtl/io_capture_packer.sv - packs ratio captured samples per word into a FWFT FIFO
// IOCAPTURE_DROPCOUNT_EN builds the saturating DropCount counter; otherwise it is tied to 0.
module io_capture_packer
  import io_capture_packer_pkg::*;
#(
  parameter int width = 8,
  parameter int ratio = 4,
  parameter int depth = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        InValid,
  input  logic [width-1:0]            In,
  input  logic                        Flush,
  output logic [width*ratio-1:0]      OutData,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [clog2(depth):0]       Level,
  output logic                        Overflow,
  output logic [DROP_COUNT_WIDTH-1:0] DropCount
);

  localparam int CW = clog2(ratio);
  localparam int AccW = width * (ratio - 1);

  logic [CW-1:0]          count_q, count_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic                   overflow_q, overflow_d;
  logic                   push;
  logic                   push_accept;
  logic                   drop;
  logic [width*ratio-1:0] word;

  // The last sample never lands in the accumulator; it goes straight into the word.
  assign word = {In, acc_q};

  always_comb begin
    count_d    = count_q;
    acc_d      = acc_q;
    push       = 1'b0;
    if (Flush) begin
      count_d = '0;
    end else if (InValid) begin
      if (count_q == CW'(ratio - 1)) begin
        push    = 1'b1;
        count_d = '0;
      end else begin
        for (int k = 0; k < ratio - 1; k++) begin
          if (count_q == CW'(k)) acc_d[k*width +: width] = In;
        end
        count_d = count_q + CW'(1);
      end
    end
    drop       = push && !push_accept;
    overflow_d = Flush ? 1'b0 : (overflow_q | drop);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q    <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef IOCAPTURE_DROPCOUNT_EN
  logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (Flush) drop_count_d = '0;
    else if (drop && (drop_count_q != DROP_COUNT_MAX)) drop_count_d = drop_count_q + DROP_COUNT_WIDTH'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) drop_count_q <= '0;
    else       drop_count_q <= drop_count_d;
  end

  assign DropCount = drop_count_q;
`else
  assign DropCount = '0;
`endif

  assign Overflow = overflow_q;

  io_word_fifo #(
    .dw   (width * ratio),
    .depth(depth)
  ) u_fifo (
    .clk        (Clock),
    .rst        (Reset),
    .push       (push),
    .push_data  (word),
    .push_accept(push_accept),
    .pop_ready  (OutReady),
    .head_data  (OutData),
    .head_valid (OutValid),
    .level      (Level)
  );

endmodule

// File: tb/tb_io_capture_packer.sv
// tb/tb_io_capture_packer.sv - directed self-checking bench for io_capture_packer
module tb_io_capture_packer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic [7:0]  In = '0;
  logic        Flush = 1'b0;
  logic [31:0] OutData;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [2:0]  Level;
  logic        Overflow;
  logic [15:0] DropCount;

  int tests = 0;
  int fails = 0;

`ifdef IOCAPTURE_DROPCOUNT_EN
  localparam logic [15:0] EXP_DROP1 = 16'd1;
`else
  localparam logic [15:0] EXP_DROP1 = 16'd0;
`endif

  io_capture_packer #(.width(8), .ratio(4), .depth(4)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .In(In), .Flush(Flush),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .Level(Level), .Overflow(Overflow), .DropCount(DropCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    InValid = 1'b1;
    In = b;
    tick();
    InValid = 1'b0;
  endtask

  function automatic logic [31:0] mk_word(input int w);
    logic [7:0] base;
    base = 8'(w * 16);
    return {base + 8'd4, base + 8'd3, base + 8'd2, base + 8'd1};
  endfunction

  task automatic send_word(input int w);
    for (int s = 1; s <= 4; s++) send(8'(w * 16 + s));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[5]  = '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[6]  = '{1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[7]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[8]  = '{1'b1, 8'hD0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[9]  = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[10] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[11] = '{1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[12] = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b1, 32'hB4B3B2B1, 3'd1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};

    // Reset state
    tick();
    chk("reset_outvalid", 32'(OutValid), 32'd0);
    chk("reset_outdata", OutData, 32'h0);
    chk("reset_level", 32'(Level), 32'd0);
    chk("reset_overflow", 32'(Overflow), 32'd0);
    chk("reset_dropcount", 32'(DropCount), 32'd0);
    Reset = 1'b0;
    tick();

    // Basic packing and flush-wins-over-sample, table driven
    for (int i = 0; i < 14; i++) begin
      InValid  = vecs[i].in_valid;
      In       = vecs[i].in_data;
      OutReady = vecs[i].out_ready;
      Flush    = vecs[i].flush;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(OutValid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_level", i), 32'(Level), 32'(vecs[i].exp_level));
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), OutData, vecs[i].exp_data);
    end
    InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;

    // Reset mid-word with a word already queued
    send_word(1);
    send(8'h55);
    send(8'h66);
    #1 Reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(OutValid), 32'd0);
    chk("async_reset_level", 32'(Level), 32'd0);
    chk("async_reset_data", OutData, 32'h0);
    tick();
    Reset = 1'b0;
    tick();
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    chk("post_reset_word", OutData, 32'hA4A3A2A1);
    chk("post_reset_level", 32'(Level), 32'd1);
    do_reset();

    // Backpressure overflow: fifth word is dropped
    for (int w = 1; w <= 5; w++) send_word(w);
    chk("ovf_level", 32'(Level), 32'd4);
    chk("ovf_flag", 32'(Overflow), 32'd1);
    chk("ovf_dropcount", 32'(DropCount), 32'(EXP_DROP1));
    OutReady = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      chk($sformatf("drain%0d_valid", w), 32'(OutValid), 32'd1);
      chk($sformatf("drain%0d_data", w), OutData, mk_word(w));
      tick();
    end
    OutReady = 1'b0;
    chk("drain_empty", 32'(OutValid), 32'd0);
    chk("drain_level", 32'(Level), 32'd0);
    chk("ovf_sticky", 32'(Overflow), 32'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_clr_ovf", 32'(Overflow), 32'd0);
    chk("flush_clr_drop", 32'(DropCount), 32'd0);
    do_reset();

    // Full FIFO with a pop on the edge the new word completes
    for (int w = 1; w <= 4; w++) send_word(w);
    send(8'h51); send(8'h52); send(8'h53);
    OutReady = 1'b1;
    send(8'h54);
    OutReady = 1'b0;
    chk("fullpop_level", 32'(Level), 32'd4);
    chk("fullpop_ovf", 32'(Overflow), 32'd0);
    chk("fullpop_drop", 32'(DropCount), 32'd0);
    OutReady = 1'b1;
    for (int w = 2; w <= 5; w++) begin
      chk($sformatf("fullpop_head%0d", w), OutData, mk_word(w));
      tick();
    end
    OutReady = 1'b0;
    chk("fullpop_empty", 32'(OutValid), 32'd0);
    do_reset();

    // Idle gaps of 0..3 cycles between samples do not change packing
    for (int s = 1; s <= 4; s++) begin
      for (int g = 0; g < s - 1; g++) tick();
      send(8'(16'h0060 + s));
      if (s < 4) chk($sformatf("gap_pending%0d", s), 32'(OutValid), 32'd0);
    end
    chk("gap_valid", 32'(OutValid), 32'd1);
    chk("gap_word", OutData, mk_word(6));

    // Held output under backpressure
    tick(); tick();
    chk("hold_valid", 32'(OutValid), 32'd1);
    chk("hold_word", OutData, mk_word(6));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
